// File: rtl/urng_pkg.sv
// Shared types and constants for the taus88 uniform source: FSM states,
// per-component shift amounts and masks, and the seed minimums.
package urng_pkg;

   typedef enum logic [1:0] {
      FILL_A = 2'd0,
      FILL_B = 2'd1,
      HOLD   = 2'd2
   } state_e;

   // component k: b = ((s << Q) ^ s) >> S ; s' = ((s & MASK) << P) ^ b
   localparam int          S0_Q    = 13;
   localparam int          S0_S    = 19;
   localparam int          S0_P    = 12;
   localparam logic [31:0] S0_MASK = 32'hFFFF_FFFE;

   localparam int          S1_Q    = 2;
   localparam int          S1_S    = 25;
   localparam int          S1_P    = 4;
   localparam logic [31:0] S1_MASK = 32'hFFFF_FFF8;

   localparam int          S2_Q    = 3;
   localparam int          S2_S    = 11;
   localparam int          S2_P    = 17;
   localparam logic [31:0] S2_MASK = 32'hFFFF_FFF0;

   localparam logic [31:0] S0_MIN = 32'd2;
   localparam logic [31:0] S1_MIN = 32'd8;
   localparam logic [31:0] S2_MIN = 32'd16;

endpackage

// File: rtl/taus_step.sv
// One combinational taus88 step: advances all three components and
// returns the combined output word.
module taus_step
   import urng_pkg::*;
(
   input  logic [31:0] s0,
   input  logic [31:0] s1,
   input  logic [31:0] s2,
   output logic [31:0] s0_nxt,
   output logic [31:0] s1_nxt,
   output logic [31:0] s2_nxt,
   output logic [31:0] word
);

   logic [31:0] b0, b1, b2;

   always_comb begin
      b0     = ((s0 << S0_Q) ^ s0) >> S0_S;
      b1     = ((s1 << S1_Q) ^ s1) >> S1_S;
      b2     = ((s2 << S2_Q) ^ s2) >> S2_S;
      s0_nxt = ((s0 & S0_MASK) << S0_P) ^ b0;
      s1_nxt = ((s1 & S1_MASK) << S1_P) ^ b1;
      s2_nxt = ((s2 & S2_MASK) << S2_P) ^ b2;
      word   = s0_nxt ^ s1_nxt ^ s2_nxt;
   end

endmodule

// File: rtl/urng_taus.sv
// taus88 uniform source for Box-Muller: two steps per sample, u0={w0,w1[31:16]},
// u1=w1[15:0]. Define URNG_SAMPLE_CNT_EN to add the sample_cnt handshake counter.
module urng_taus
   import urng_pkg::*;
#(
   parameter logic [31:0] SEED0 = 32'h1234_5678,
   parameter logic [31:0] SEED1 = 32'h8765_4321,
   parameter logic [31:0] SEED2 = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        seed_load,
   input  logic [95:0] seed_data,
   input  logic        ready_in,
`ifdef URNG_SAMPLE_CNT_EN
   output logic [31:0] sample_cnt,
`endif
   output logic        valid_out,
   output logic [47:0] u0,
   output logic [15:0] u1
);

   state_e      state, state_nxt;
   logic [31:0] s0, s1, s2, a;
   logic [31:0] s0_nxt, s1_nxt, s2_nxt, a_nxt;
   logic [31:0] st0, st1, st2, word;
   logic [47:0] u0_nxt;
   logic [15:0] u1_nxt;
   logic        vld_nxt;

   // single step unit shared by both fill states
   taus_step u_step (
      .s0     (s0),
      .s1     (s1),
      .s2     (s2),
      .s0_nxt (st0),
      .s1_nxt (st1),
      .s2_nxt (st2),
      .word   (word)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= FILL_A;
         s0        <= SEED0;
         s1        <= SEED1;
         s2        <= SEED2;
         a         <= '0;
         u0        <= '0;
         u1        <= '0;
         valid_out <= 1'b0;
      end else begin
         state     <= state_nxt;
         s0        <= s0_nxt;
         s1        <= s1_nxt;
         s2        <= s2_nxt;
         a         <= a_nxt;
         u0        <= u0_nxt;
         u1        <= u1_nxt;
         valid_out <= vld_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      s0_nxt    = s0;
      s1_nxt    = s1;
      s2_nxt    = s2;
      a_nxt     = a;
      u0_nxt    = u0;
      u1_nxt    = u1;
      vld_nxt   = valid_out;
      if (seed_load) begin
         // degenerate components would lock the generator; fall back to defaults
         s0_nxt    = (seed_data[31:0]  < S0_MIN) ? SEED0 : seed_data[31:0];
         s1_nxt    = (seed_data[63:32] < S1_MIN) ? SEED1 : seed_data[63:32];
         s2_nxt    = (seed_data[95:64] < S2_MIN) ? SEED2 : seed_data[95:64];
         vld_nxt   = 1'b0;
         state_nxt = FILL_A;
      end else begin
         case (state)
            FILL_A: begin
               {s0_nxt, s1_nxt, s2_nxt} = {st0, st1, st2};
               a_nxt     = word;
               state_nxt = FILL_B;
            end
            FILL_B: begin
               {s0_nxt, s1_nxt, s2_nxt} = {st0, st1, st2};
               u0_nxt    = {a, word[31:16]};
               u1_nxt    = word[15:0];
               vld_nxt   = 1'b1;
               state_nxt = HOLD;
            end
            HOLD: begin
               if (ready_in) begin
                  vld_nxt   = 1'b0;
                  state_nxt = FILL_A;
               end
            end
            default: state_nxt = FILL_A;
         endcase
      end
   end

`ifdef URNG_SAMPLE_CNT_EN
   logic [31:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                         cnt_q <= '0;
      else if (seed_load)               cnt_q <= '0;
      else if (valid_out && ready_in)   cnt_q <= cnt_q + 32'd1;
   end

   assign sample_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_urng_taus.sv
// Scoreboard bench for urng_taus: a taus88 reference model pushes expected
// {u0,u1} pairs on each (re)seed; samples are popped as the DUT presents them.
module tb_urng_taus;

   localparam logic [31:0] D0 = 32'h1234_5678;
   localparam logic [31:0] D1 = 32'h8765_4321;
   localparam logic [31:0] D2 = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        seed_load = 1'b0;
   logic [95:0] seed_data = '0;
   logic        ready_in = 1'b0;
   logic        valid_out;
   logic [47:0] u0;
   logic [15:0] u1;
`ifdef URNG_SAMPLE_CNT_EN
   logic [31:0] sample_cnt;
`endif

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] ms0, ms1, ms2;
   logic [63:0] exp_q[$];

   always #5 clk = ~clk;

   urng_taus dut (
      .clk        (clk),
      .rst        (rst),
      .seed_load  (seed_load),
      .seed_data  (seed_data),
      .ready_in   (ready_in),
`ifdef URNG_SAMPLE_CNT_EN
      .sample_cnt (sample_cnt),
`endif
      .valid_out  (valid_out),
      .u0         (u0),
      .u1         (u1)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // reference taus88, written as in the C original
   task automatic m_step(output logic [31:0] w);
      logic [31:0] b;
      b   = ((ms0 << 13) ^ ms0) >> 19;
      ms0 = ((ms0 & 32'hFFFFFFFE) << 12) ^ b;
      b   = ((ms1 << 2) ^ ms1) >> 25;
      ms1 = ((ms1 & 32'hFFFFFFF8) << 4) ^ b;
      b   = ((ms2 << 3) ^ ms2) >> 11;
      ms2 = ((ms2 & 32'hFFFFFFF0) << 17) ^ b;
      w   = ms0 ^ ms1 ^ ms2;
   endtask

   task automatic m_seed(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      ms0 = (a < 32'd2)  ? D0 : a;
      ms1 = (b < 32'd8)  ? D1 : b;
      ms2 = (c < 32'd16) ? D2 : c;
      exp_q.delete();
   endtask

   task automatic m_push(input int n);
      logic [31:0] w0, w1;
      repeat (n) begin
         m_step(w0);
         m_step(w1);
         exp_q.push_back({w0, w1});
      end
   endtask

   task automatic wait_valid(input string tag, output int n);
      n = 0;
      while (!valid_out && n < 20) begin
         tick;
         n++;
      end
      if (!valid_out) chk({tag, "_timeout"}, {63'd0, valid_out}, 64'd1);
   endtask

   task automatic chk_sample(input string tag);
      logic [63:0] e;
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = exp_q.pop_front();
         chk(tag, {u0, u1}, e);
      end
   endtask

   // wait for a sample expected 2 edges out, check latency and data
   task automatic get_sample(input string tag);
      int n;
      wait_valid(tag, n);
      chk({tag, "_lat"}, 64'(n), 64'd2);
      chk_sample(tag);
   endtask

   task automatic run8(input string tag);
      m_seed(D0, D1, D2);
      m_push(8);
      get_sample($sformatf("%s0", tag));
      for (int i = 1; i < 8; i++) begin
         tick;
         chk($sformatf("%s_vlow%0d", tag, i), {63'd0, valid_out}, 64'd0);
         get_sample($sformatf("%s%0d", tag, i));
      end
   endtask

   initial begin
      logic [63:0] held;

      // reset state
      tick;
      tick;
      chk("rst_vld", {63'd0, valid_out}, 64'd0);
      chk("rst_u", {u0, u1}, 64'd0);
`ifdef URNG_SAMPLE_CNT_EN
      chk("rst_cnt", {32'd0, sample_cnt}, 64'd0);
`endif

      // default seeds, free-running
      ready_in = 1'b1;
      rst      = 1'b1;
      run8("seq");
`ifdef URNG_SAMPLE_CNT_EN
      chk("cnt7", {32'd0, sample_cnt}, 64'd7);
`endif

      // backpressure: restart, hold first sample
      rst = 1'b0;
      tick;
      rst      = 1'b1;
      ready_in = 1'b0;
      m_seed(D0, D1, D2);
      m_push(2);
      get_sample("bp0");
      held = {u0, u1};
      for (int i = 0; i < 10; i++) begin
         tick;
         chk($sformatf("bp_hold%0d", i), {u0, u1}, held);
         chk($sformatf("bp_vhold%0d", i), {63'd0, valid_out}, 64'd1);
      end
      ready_in = 1'b1;
      tick;
      chk("bp_vdrop", {63'd0, valid_out}, 64'd0);
      ready_in = 1'b0;
      get_sample("bp1");

      // seed load while a sample is held; s0 below minimum
      seed_load = 1'b1;
      seed_data = {32'd100, 32'd50, 32'd0};
      tick;
      seed_load = 1'b0;
      chk("sl_vld", {63'd0, valid_out}, 64'd0);
      m_seed(32'd0, 32'd50, 32'd100);
      m_push(4);
      get_sample("sl0");
      ready_in = 1'b1;
      for (int i = 1; i < 4; i++) begin
         tick;
         get_sample($sformatf("sl%0d", i));
      end

      // seed load collides with a handshake in HOLD; s1 below minimum
      seed_load = 1'b1;
      seed_data = {32'hCAFE_F00D, 32'd5, 32'h0123_4567};
      tick;
      seed_load = 1'b0;
      chk("slr_vld", {63'd0, valid_out}, 64'd0);
`ifdef URNG_SAMPLE_CNT_EN
      chk("slr_cnt", {32'd0, sample_cnt}, 64'd0);
`endif
      m_seed(32'h0123_4567, 32'd5, 32'hCAFE_F00D);
      m_push(2);
      get_sample("slr0");
      tick;
      get_sample("slr1");

      // async reset in the middle of FILL_B
      tick;
      tick;
      #2;
      rst = 1'b0;
      #1;
      chk("arst_vld", {63'd0, valid_out}, 64'd0);
      chk("arst_u", {u0, u1}, 64'd0);
      tick;
      tick;
      rst = 1'b1;
      run8("rs");

`ifdef URNG_SAMPLE_CNT_EN
      chk("cnt_rs7", {32'd0, sample_cnt}, 64'd7);
      ready_in = 1'b0;
      tick;
      force dut.cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.cnt_q;
      ready_in = 1'b1;
      tick;
      chk("cnt_wrap", {32'd0, sample_cnt}, 64'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/urng_taus.md
Name: urng_taus

Overview:
- Uniform random number source feeding the Box-Muller datapath.
- Produces u1, the 16-bit phase input consumed directly by cos_sine, and u0, the 48-bit input consumed by the log/sqrt stage.
- Built on a combined three-component Tausworthe generator (taus88), advanced two steps per output sample.
- Seedable at run time; valid/ready handshake with backpressure toward the downstream stages.

Parameters:
- SEED0, 32'h1234_5678, reset value of component s0 (must be >= 2)
- SEED1, 32'h8765_4321, reset value of component s1 (must be >= 8)
- SEED2, 32'hDEAD_BEEF, reset value of component s2 (must be >= 16)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- seed_load  in  1  single-cycle pulse; load seed_data into s0/s1/s2
- seed_data  in  96  {s2, s1, s0}, each 32 bits
- ready_in  in  1  downstream can accept a sample this cycle
- valid_out  out  1  u0/u1 hold a fresh sample
- u0  out  48  uniform word for the log/sqrt stage
- u1  out  16  uniform word for cos_sine.U1

Behaviour:
- Reset (rst=0, asynchronous):
  - s0/s1/s2 = SEED0/1/2
  - valid_out=0, u0=0, u1=0
  - state = FILL_A
- Tausworthe step (combinational, one step):
  - b0=((s0<<13)^s0)>>19; s0'=((s0&32'hFFFFFFFE)<<12)^b0
  - b1=((s1<<2)^s1)>>25; s1'=((s1&32'hFFFFFFF8)<<4)^b1
  - b2=((s2<<3)^s2)>>11; s2'=((s2&32'hFFFFFFF0)<<17)^b2
  - word = s0'^s1'^s2'
  - All arithmetic is 32-bit logical; shifts discard overflow.
- State machine, 2-bit encoding:
  - FILL_A: step; latch word into internal reg a; go to FILL_B.
  - FILL_B: step; word is b; register u0={a, b[31:16]}, u1=b[15:0]; valid_out=1; go to HOLD.
  - HOLD: no step. If ready_in=1: valid_out=0 next cycle, go to FILL_A. Otherwise u0/u1/valid_out stay stable.
- Latency and throughput:
  - After rst deasserts, valid_out rises on the 2nd rising clk edge.
  - With ready_in held at 1, one sample every 3 cycles; valid_out is high for exactly 1 cycle per sample.
- Handshake:
  - Transfer occurs on a clk edge where valid_out=1 and ready_in=1.
  - ready_in while valid_out=0 has no effect.
  - u0/u1 must not change while valid_out=1 and ready_in=0.
- Seed load:
  - seed_load=1 at a rising edge takes priority over everything: s0/s1/s2 load from seed_data, valid_out=0, state=FILL_A. Any held sample is discarded, with or without ready_in.
  - A seed component below its minimum (s0<2, s1<8, s2<16) is replaced by the corresponding SEED parameter; the others load as given.
  - The next valid sample appears 2 edges after the load edge.
- Reset mid-operation: immediate return to reset values regardless of state; no partial sample is emitted.

Optional Feature:
- Macro: URNG_SAMPLE_CNT_EN.
- Defined:
  - Adds output port sample_cnt [31:0].
  - Counts completed handshakes (valid_out&ready_in at an edge).
  - Reset value 0; cleared by seed_load; wraps 32'hFFFFFFFF -> 0.
- Undefined: port, counter and logic are absent; all other behaviour is identical.

Decomposition:
- Package urng_pkg holds:
  - state typedef: FILL_A=0, FILL_B=1, HOLD=2
  - per-component shift constants (13/19/12, 2/25/4, 3/11/17) and masks
  - seed minimums (2, 8, 16)
- Sub-module taus_step: purely combinational; inputs s0/s1/s2; outputs next s0/s1/s2 and word. Instantiated once and shared by FILL_A and FILL_B.

Test Plan:
- Reset then ready_in=1 with default seeds:
  - valid_out high on edge 2 after release, then every 3 cycles.
  - First 8 u0/u1 pairs match a C taus88 model: u0={w0, w1[31:16]}, u1=w1[15:0].
- Backpressure: ready_in=0 for 10 cycles while valid_out=1 -> u0/u1/valid_out unchanged; ready_in=1 -> valid_out=0 next cycle; next sample equals model words w2/w3.
- seed_load with seed_data={32'd100, 32'd50, 32'd0}:
  - s0 is substituted by SEED0, s1=50, s2=100.
  - Output sequence matches the model seeded the same way.
  - A previously held sample is dropped.
- seed_load asserted together with ready_in=1 in HOLD -> seed wins; valid_out=0; sample_cnt does not increment; if URNG_SAMPLE_CNT_EN, cnt=0.
- Assert rst=0 asynchronously mid-FILL_B -> outputs zero immediately; after release the sequence restarts identical to the first scenario.
- URNG_SAMPLE_CNT_EN defined: 5 handshakes -> sample_cnt=5; force counter to 32'hFFFFFFFF, one handshake -> 0.
